// File: rtl/uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_cfg : UART transmitter, one-word holding buffer, per-word parity  |
// | and stop-bit configuration.                              Revision: 1.0   |
// +--------------------------------------------------------------------------+
module uart_tx_cfg #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             STOP_TWO,
  output logic             READY,
  output logic             TX_OUT,
  output logic             Busy,
  output logic             DONE
);

  localparam int c_bcw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_dcw = $clog2(WIDTH);
  localparam logic [c_bcw-1:0] c_bit_last  = c_bcw'(CLKS_PER_BIT - 1);
  localparam logic [c_dcw-1:0] c_data_last = c_dcw'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t           r_state, w_state_next;
  logic             r_buf_full;
  logic [WIDTH-1:0] r_buf_data;
  logic             r_buf_par_en, r_buf_par_typ, r_buf_stop_two;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [c_dcw-1:0] r_data_cnt;
  logic [c_bcw-1:0] r_bit_cnt;
  logic             r_par_en, r_par_bit, r_stop_two;
  logic             w_bit_done, w_frame_end, w_load, w_accept, w_tx_next;

  assign READY       = ~r_buf_full;
  assign w_accept    = DATA_VALID & ~r_buf_full;
  assign w_bit_done  = (r_bit_cnt == c_bit_last);
  assign w_frame_end = w_bit_done && ((r_state == STOP1 && !r_stop_two) || r_state == STOP2);
  assign w_load      = r_buf_full && (r_state == IDLE || w_frame_end);
  assign DONE        = w_frame_end;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    case (r_state)
      IDLE:   if (r_buf_full) w_state_next = START;
      START:  if (w_bit_done) w_state_next = DATA;
      DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          if (r_data_cnt == c_data_last) w_state_next = r_par_en ? PARITY : STOP1;
        end
      end
      PARITY: if (w_bit_done) w_state_next = STOP1;
      STOP1:  if (w_bit_done) w_state_next = r_stop_two ? STOP2 : (r_buf_full ? START : IDLE);
      STOP2:  if (w_bit_done) w_state_next = r_buf_full ? START : IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_load) w_shift_next = r_buf_data;
    // The line is registered from the next state so it lines up with r_state.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = r_par_bit;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_cnt  <= '0;
      r_data_cnt <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop_two <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      TX_OUT  <= w_tx_next;
      Busy    <= (w_state_next != IDLE);
      if (r_state == IDLE || w_bit_done) r_bit_cnt <= '0;
      else                               r_bit_cnt <= r_bit_cnt + c_bcw'(1);
      if (w_load) begin
        r_data_cnt <= '0;
        r_par_en   <= r_buf_par_en;
        r_par_bit  <= (^r_buf_data) ^ r_buf_par_typ;
        r_stop_two <= r_buf_stop_two;
      end else if (r_state == DATA && w_bit_done) begin
        r_data_cnt <= r_data_cnt + c_dcw'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_buf_full     <= 1'b0;
      r_buf_data     <= '0;
      r_buf_par_en   <= 1'b0;
      r_buf_par_typ  <= 1'b0;
      r_buf_stop_two <= 1'b0;
    end else if (w_accept) begin
      r_buf_full     <= 1'b1;
      r_buf_data     <= P_DATA;
      r_buf_par_en   <= PAR_EN;
      r_buf_par_typ  <= PAR_TYP;
      r_buf_stop_two <= STOP_TWO;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// tb_uart_tx_cfg: hand-computed frame table, corner sequences and random traffic
// against a frame-level model, on a 1-clock-per-bit and a 4-clock-per-bit instance.
module tb_uart_tx_cfg;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP_TWO = 1'b0;
  logic       ready1, tx1, busy1, done1;
  logic       ready4, tx4, busy4, done4;

  always #5 CLK = ~CLK;

  uart_tx_cfg #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP_TWO(STOP_TWO),
    .READY(ready1), .TX_OUT(tx1), .Busy(busy1), .DONE(done1)
  );

  uart_tx_cfg #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP_TWO(STOP_TWO),
    .READY(ready4), .TX_OUT(tx4), .Busy(busy4), .DONE(done4)
  );

  int n_vec = 0;
  int n_err = 0;

  // Frame-level model: holding slot plus the bit list of the frame on the line.
  int         m_cpb [2] = '{1, 4};
  logic       m_full [2];
  logic [7:0] m_data [2];
  logic       m_pe [2], m_pt [2], m_st [2];
  logic [19:0] m_bits [2];
  int         m_tot [2], m_rem [2];

  typedef struct {
    logic [7:0]  data;
    logic        pe, pt, st;
    int          inst;
    logic [19:0] seq;   // first transmitted bit is seq[len-1]
    int          len;
  } vec_t;
  vec_t tbl [6];

  function automatic logic txs(input int i);   return (i != 0) ? tx4 : tx1;     endfunction
  function automatic logic busys(input int i); return (i != 0) ? busy4 : busy1; endfunction
  function automatic logic dones(input int i); return (i != 0) ? done4 : done1; endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0;
      m_rem[i]  = 0;
      m_tot[i]  = 0;
    end
  endtask

  task automatic model_edge(input int i);
    logic acc;
    int   n;
    acc = DATA_VALID && !m_full[i];
    if (m_rem[i] > 0) m_rem[i]--;
    if (m_rem[i] == 0 && m_full[i]) begin
      m_bits[i]    = '0;
      m_bits[i][0] = 1'b0;
      for (int j = 0; j < 8; j++) m_bits[i][1+j] = m_data[i][j];
      n = 9;
      if (m_pe[i]) begin m_bits[i][n] = (^m_data[i]) ^ m_pt[i]; n++; end
      m_bits[i][n] = 1'b1; n++;
      if (m_st[i]) begin m_bits[i][n] = 1'b1; n++; end
      m_tot[i]  = n * m_cpb[i];
      m_rem[i]  = m_tot[i];
      m_full[i] = 1'b0;
    end
    if (acc) begin
      m_full[i] = 1'b1;
      m_data[i] = P_DATA;
      m_pe[i]   = PAR_EN;
      m_pt[i]   = PAR_TYP;
      m_st[i]   = STOP_TWO;
    end
  endtask

  task automatic model_check();
    logic etx;
    for (int i = 0; i < 2; i++) begin
      etx = (m_rem[i] > 0) ? m_bits[i][(m_tot[i] - m_rem[i]) / m_cpb[i]] : 1'b1;
      check((i == 0) ? "m_tx1"    : "m_tx4",    txs(i),   etx);
      check((i == 0) ? "m_busy1"  : "m_busy4",  busys(i), m_rem[i] > 0);
      check((i == 0) ? "m_done1"  : "m_done4",  dones(i), m_rem[i] == 1);
      check((i == 0) ? "m_ready1" : "m_ready4", (i == 0) ? ready1 : ready4, !m_full[i]);
    end
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic pe, input logic pt,
                     input logic st);
    DATA_VALID = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP_TWO = st;
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    #1;
    model_check();
  endtask

  task automatic idle();
    cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy1 || busy4 || !ready1 || !ready4) && k < 300) begin
      idle();
      k++;
    end
    check("wait_idle", {6'd0, busy1, busy4}, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0, 20'b01010010101,  11};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 0, 20'b01110000011,  11};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 0, 20'b01110000001,  11};
    tbl[3] = '{8'h07, 1'b0, 1'b0, 1'b1, 0, 20'b01110000011,  11};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 0, 20'b001011010111, 12};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1, 20'b0001111001,   10};

    // Asynchronous reset, checked before any clock edge.
    model_reset();
    #2 RST = 1'b0;
    #1;
    check("rst_tx1", tx1, 1'b1);     check("rst_busy1", busy1, 1'b0);
    check("rst_ready1", ready1, 1'b1); check("rst_done1", done1, 1'b0);
    check("rst_tx4", tx4, 1'b1);     check("rst_busy4", busy4, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    for (int v = 0; v < 6; v++) begin
      int cpbv;
      cpbv = (tbl[v].inst != 0) ? 4 : 1;
      wait_idle();
      cyc(1'b1, tbl[v].data, tbl[v].pe, tbl[v].pt, tbl[v].st);
      for (int c = 0; c < tbl[v].len * cpbv; c++) begin
        idle();
        check("tbl_tx",   txs(tbl[v].inst),   tbl[v].seq[tbl[v].len - 1 - c / cpbv]);
        check("tbl_busy", busys(tbl[v].inst), 1'b1);
        check("tbl_done", dones(tbl[v].inst), c == tbl[v].len * cpbv - 1);
      end
      idle();
      check("tbl_end_busy", busys(tbl[v].inst), 1'b0);
    end

    // Back-to-back: 0x22 waits in the buffer, starts right after 0x11's stop bit.
    wait_idle();
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    check("b2b_busy_c1", busy1, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    check("b2b_ready_c2", ready1, 1'b0);
    for (int c = 3; c <= 21; c++) begin
      idle();
      if (c <= 20) check("b2b_busy", busy1, 1'b1);
      if (c <= 10) check("b2b_ready_held", ready1, 1'b0);
      if (c == 10) begin check("b2b_stop1", tx1, 1'b1); check("b2b_done1", done1, 1'b1); end
      if (c == 11) begin check("b2b_start2", tx1, 1'b0); check("b2b_ready_free", ready1, 1'b1); end
      if (c == 13) check("b2b_bit1", tx1, 1'b1);
      if (c == 20) check("b2b_done2", done1, 1'b1);
      if (c == 21) check("b2b_idle", busy1, 1'b0);
    end

    // Config inputs toggle mid-frame; the second word carries its own config.
    wait_idle();
    cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      if (c == 5) cyc(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
      else        cyc(1'b0, 8'hFF, 1'(c), 1'(c), ~1'(c));
      if (c == 10) check("cfg_par1", tx1, 1'b0);
      if (c == 11) check("cfg_done1", done1, 1'b1);
      if (c == 12) check("cfg_one_stop", tx1, 1'b0);
      if (c == 21) check("cfg_par2", tx1, 1'b1);
      if (c == 22) check("cfg_stop2a", done1, 1'b0);
      if (c == 23) check("cfg_done2", done1, 1'b1);
      if (c == 24) check("cfg_idle", busy1, 1'b0);
    end

    // Reset during data bit 3 with a second word buffered.
    wait_idle();
    cyc(1'b1, 8'h96, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) cyc(c == 2, 8'h03, 1'b0, 1'b0, 1'b0);
    #2 RST = 1'b0;
    model_reset();
    #1;
    check("arst_tx", tx1, 1'b1);      check("arst_busy", busy1, 1'b0);
    check("arst_ready", ready1, 1'b1); check("arst_done", done1, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 20; c++) begin
      idle();
      check("post_rst_tx", tx1, 1'b1);
      check("post_rst_busy", busy1, 1'b0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      cyc($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame; legal range 5..16.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1: CLK cycles per transmitted bit; legal range >=1.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port P_DATA  input  WIDTH  parallel data word, sent LSB first.
REQ-006 SHALL have port DATA_VALID  input  1  word-offer strobe; word is accepted on an edge where DATA_VALID=1 and READY=1.
REQ-007 SHALL have port PAR_EN  input  1  1 = parity bit inserted after the data bits.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port STOP_TWO  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port READY  output  1  holding buffer empty; word can be accepted.
REQ-011 SHALL have port TX_OUT  output  1  serial line, registered; idle level 1.
REQ-012 SHALL have port Busy  output  1  frame in progress (FSM not IDLE), registered.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse on the last cycle of the final stop bit.

Function
REQ-014 SHALL contain a one-entry holding buffer: an accepted P_DATA word is captured together with PAR_EN, PAR_TYP and STOP_TWO; READY = not buffer-full (combinational).
REQ-015 SHALL ignore DATA_VALID while READY=0; P_DATA and config inputs are don't-care outside accept edges.
REQ-016 SHALL run FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-017 IDLE -> START on an edge where the buffer is full; the same edge moves buffer contents into the shift register and config registers and empties the buffer.
REQ-018 Each of START, each DATA bit, PARITY, STOP1 and STOP2 SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that is cleared on every bit boundary.
REQ-019 START drives TX_OUT=0; DATA drives bit i of the word in its i-th bit period, i=0..WIDTH-1; after WIDTH bits go to PARITY if latched PAR_EN=1, else STOP1.
REQ-020 PARITY SHALL drive XOR of the WIDTH latched data bits when PAR_TYP=0, its inverse when PAR_TYP=1.
REQ-021 STOP1 and STOP2 drive TX_OUT=1; STOP1 -> STOP2 if latched STOP_TWO=1, else end of frame.
REQ-022 At end of frame: if buffer full go directly to START, with no idle cycle between frames; otherwise go to IDLE.
REQ-023 Frame length SHALL be (1+WIDTH+PAR_EN+1+STOP_TWO)*CLKS_PER_BIT cycles.
REQ-024 Latency: word accepted at edge k while IDLE and buffer empty -> TX_OUT=0 and Busy=1 after edge k+1.
REQ-025 A word may be accepted at any time the buffer is empty, including mid-frame; the buffer is never overwritten while full.
REQ-026 Config changes on the inputs mid-frame SHALL NOT affect the frame in progress.
REQ-027 Busy=1 in every state except IDLE; DONE=1 only during the final cycle of the last stop bit.

Reset
REQ-028 RST=0 SHALL asynchronously force: FSM to IDLE, buffer empty (READY=1), TX_OUT=1, Busy=0, DONE=0, and bit and shift counters to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame at once; TX_OUT=1 while RST=0. After release, no partial frame resumes and the buffered word is discarded.

Verification
REQ-030 WIDTH=8, CLKS_PER_BIT=1, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP_TWO=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Busy high 11 cycles; DONE in cycle 11.
REQ-031 P_DATA=0x07, PAR_EN=1: PAR_TYP=0 -> parity bit 1; PAR_TYP=1 -> parity bit 0. PAR_EN=0, STOP_TWO=1 -> 11-cycle frame ending in two 1s.
REQ-032 CLKS_PER_BIT=4, 0x3C, no parity, one stop -> each bit held exactly 4 cycles; frame 40 cycles.
REQ-033 Offer 0x11 and then 0x22 during the first frame -> second accepted while frame 1 runs, READY=0 until frame 2 starts; start bit of 0x22 immediately follows the stop bit of 0x11; Busy stays 1 throughout.
REQ-034 Toggle PAR_TYP and STOP_TWO mid-frame -> frame in progress unchanged; next frame uses the values latched at its accept.
REQ-035 Assert RST=0 during DATA bit 3 -> TX_OUT=1, Busy=0, READY=1 immediately; after release, line idle until a new DATA_VALID.
